// File: rtl/plc_pkg.sv
// Shared definitions for the PLC tuple collector: state encoding and slot slicing helper.
package plc_pkg;

  typedef enum logic [1:0] {
    PLC_IDLE    = 2'b00,
    PLC_COLLECT = 2'b01,
    PLC_HOLD    = 2'b10
  } plc_state_e;

  // MS bit index of slot `slot` in a packed vector of `len` entries of `w` bits,
  // slot 0 occupying the most significant slice.
  function automatic int slot_msb(input int slot, input int w, input int len);
    return (len - slot) * w - 1;
  endfunction

endpackage

// File: rtl/plc_tuple_shadow.sv
// Slot-indexed shadow buffer for the (addr, way) entries of the tuple being collected.
// nxt_addr/nxt_way expose the contents as they will be after this cycle's write,
// so the final entry can be committed to the output in the same cycle it arrives.
module plc_tuple_shadow
  import plc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WAY_WIDTH  = 4,
  parameter int TUPLE_LEN  = 2,
  parameter int IDX_W      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            we,
  input  logic [IDX_W-1:0]                idx,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [WAY_WIDTH-1:0]            way,
  output logic [TUPLE_LEN*ADDR_WIDTH-1:0] nxt_addr,
  output logic [TUPLE_LEN*WAY_WIDTH-1:0]  nxt_way
);

  logic [TUPLE_LEN*ADDR_WIDTH-1:0] shd_addr_q, shd_addr_d;
  logic [TUPLE_LEN*WAY_WIDTH-1:0]  shd_way_q,  shd_way_d;

  // Next shadow contents: clear, or overwrite the addressed slot.
  always_comb begin
    shd_addr_d = shd_addr_q;
    shd_way_d  = shd_way_q;
    if (clr) begin
      shd_addr_d = '0;
      shd_way_d  = '0;
    end else if (we) begin
      for (int i = 0; i < TUPLE_LEN; i++) begin
        if (idx == IDX_W'(i)) begin
          shd_addr_d[slot_msb(i, ADDR_WIDTH, TUPLE_LEN) -: ADDR_WIDTH] = addr;
          shd_way_d[slot_msb(i, WAY_WIDTH, TUPLE_LEN) -: WAY_WIDTH]    = way;
        end
      end
    end
  end

  // Shadow storage register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_addr_q <= '0;
      shd_way_q  <= '0;
    end else begin
      shd_addr_q <= shd_addr_d;
      shd_way_q  <= shd_way_d;
    end
  end

  assign nxt_addr = shd_addr_d;
  assign nxt_way  = shd_way_d;

endmodule

// File: rtl/plc_tuple_collector.sv
// PLC tuple collector: after an indicator pulse, gathers TUPLE_LEN (addr, way)
// writes and presents them as one tuple on a valid/ready handshake. Supports
// abort, optional idle timeout and a single pending indicator during HOLD.
module plc_tuple_collector
  import plc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WAY_WIDTH  = 4,
  parameter int TUPLE_LEN  = 2,
  parameter int TIMEOUT    = 0,
  parameter int CNT_W      = $clog2(TUPLE_LEN + 1),
  parameter int TO_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            indicator,
  input  logic                            write_en,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [WAY_WIDTH-1:0]            way,
  input  logic                            abort,
  input  logic                            out_ready,
  output logic [TUPLE_LEN*ADDR_WIDTH-1:0] tuple_addr,
  output logic [TUPLE_LEN*WAY_WIDTH-1:0]  tuple_way,
  output logic                            tuple_valid,
  output logic [CNT_W-1:0]                fill_count,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(TUPLE_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  plc_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                fill_q, fill_d;
  logic [TO_W-1:0]                 to_q, to_d;
  logic                            pend_q, pend_d;
  logic                            terr_q, terr_d;
  logic [TUPLE_LEN*ADDR_WIDTH-1:0] taddr_q, taddr_d;
  logic [TUPLE_LEN*WAY_WIDTH-1:0]  tway_q, tway_d;

  logic                            shd_clr;
  logic                            shd_we;
  logic [TUPLE_LEN*ADDR_WIDTH-1:0] shd_nxt_addr;
  logic [TUPLE_LEN*WAY_WIDTH-1:0]  shd_nxt_way;

  logic final_wr;
  logic to_expire;

  // abort outranks write_en; a write on the expiry cycle outranks the timeout.
  assign shd_we    = (state_q == PLC_COLLECT) && write_en && !abort;
  assign final_wr  = shd_we && (fill_q == LAST_SLOT);
  assign to_expire = (TIMEOUT > 0) && (state_q == PLC_COLLECT) && !abort &&
                     !write_en && (to_q == TO_LAST);

  plc_tuple_shadow #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAY_WIDTH  (WAY_WIDTH),
    .TUPLE_LEN  (TUPLE_LEN),
    .IDX_W      (CNT_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (shd_clr),
    .we       (shd_we),
    .idx      (fill_q),
    .addr     (addr),
    .way      (way),
    .nxt_addr (shd_nxt_addr),
    .nxt_way  (shd_nxt_way)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PLC_IDLE;
      fill_q  <= '0;
      to_q    <= '0;
      pend_q  <= 1'b0;
      terr_q  <= 1'b0;
      taddr_q <= '0;
      tway_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
      terr_q  <= terr_d;
      taddr_q <= taddr_d;
      tway_q  <= tway_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLC_IDLE: begin
        if (indicator) state_d = PLC_COLLECT;
      end
      PLC_COLLECT: begin
        if (abort)          state_d = PLC_IDLE;
        else if (final_wr)  state_d = PLC_HOLD;
        else if (to_expire) state_d = PLC_IDLE;
      end
      PLC_HOLD: begin
        if (out_ready) state_d = (pend_q || indicator) ? PLC_COLLECT : PLC_IDLE;
      end
      default: state_d = PLC_IDLE;
    endcase
  end

  // Counters, pending flag, tuple capture and shadow control.
  always_comb begin
    fill_d  = fill_q;
    to_d    = to_q;
    pend_d  = pend_q;
    terr_d  = 1'b0;
    taddr_d = taddr_q;
    tway_d  = tway_q;
    shd_clr = 1'b0;
    case (state_q)
      PLC_IDLE: begin
        if (indicator) begin
          fill_d  = '0;
          to_d    = '0;
          shd_clr = 1'b1;
        end
      end
      PLC_COLLECT: begin
        if (abort) begin
          fill_d = '0;
          to_d   = '0;
        end else if (write_en) begin
          to_d = '0;
          if (final_wr) begin
            fill_d  = '0;
            taddr_d = shd_nxt_addr;
            tway_d  = shd_nxt_way;
          end else begin
            fill_d = fill_q + CNT_W'(1);
          end
        end else if (to_expire) begin
          fill_d = '0;
          to_d   = '0;
          terr_d = 1'b1;
        end else if (TIMEOUT > 0) begin
          to_d = to_q + TO_W'(1);
        end
      end
      PLC_HOLD: begin
        if (out_ready) begin
          pend_d = 1'b0;
          if (pend_q || indicator) begin
            fill_d  = '0;
            to_d    = '0;
            shd_clr = 1'b1;
          end
        end else if (indicator) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        fill_d = '0;
        to_d   = '0;
        pend_d = 1'b0;
      end
    endcase
  end

  assign tuple_addr  = taddr_q;
  assign tuple_way   = tway_q;
  assign tuple_valid = (state_q == PLC_HOLD);
  assign fill_count  = fill_q;
  assign busy        = (state_q != PLC_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: doc/plc_tuple_collector.md
Name: plc_tuple_collector

Overview:
- Parametrised successor to the PLC two-entry add-tuple capture stage in the PLC execution path.
- After an `indicator` pulse, collects `TUPLE_LEN` (addr, way) write events into a tuple.
- Presents the completed tuple on a valid/ready handshake, so the downstream PLC table can stall without losing data.
- Adds timeout, abort, one-deep pending-indicator queueing, and a captured-count output.

Parameters:
- ADDR_WIDTH, 8, width of one captured address.
- WAY_WIDTH, 4, width of one captured way.
- TUPLE_LEN, 2, entries per tuple; legal range 2..8.
- TIMEOUT, 0, max idle cycles in COLLECT between writes; 0 disables the timeout.
- CNT_W, $clog2(TUPLE_LEN+1), width of the entry counter (derived, not overridden).
- TO_W, 16, width of the timeout counter; TIMEOUT must be < 2**TO_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- indicator  in  1  start-of-tuple pulse.
- write_en  in  1  qualifies addr/way for capture.
- addr  in  ADDR_WIDTH  address to capture.
- way  in  WAY_WIDTH  way to capture.
- abort  in  1  discard the partial tuple.
- out_ready  in  1  downstream accepts the tuple.
- tuple_addr  out  TUPLE_LEN*ADDR_WIDTH  completed addresses; entry 0 in the MS slice.
- tuple_way  out  TUPLE_LEN*WAY_WIDTH  completed ways; entry 0 in the MS slice.
- tuple_valid  out  1  tuple available.
- fill_count  out  CNT_W  entries captured in the current collection.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse when a collection times out.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - tuple_addr, tuple_way, the shadow buffer, fill_count, timeout counter and pending flag all 0.
  - tuple_valid=0, timeout_err=0.
  - Reset mid-collection or mid-HOLD discards everything, with no valid pulse.
- States:
  - IDLE: wait for indicator.
  - COLLECT: capture entries into the shadow buffer.
  - HOLD: tuple_valid=1, wait for out_ready.
- IDLE:
  - indicator=1 -> COLLECT, fill_count=0, timeout counter=0.
  - write_en in IDLE is ignored, including the same cycle as indicator.
- COLLECT, write_en=1:
  - addr/way are written into shadow slot fill_count, with slot 0 in the MS slice.
  - fill_count increments; the timeout counter clears.
- COLLECT, final write (fill_count==TUPLE_LEN-1 and write_en=1):
  - The full shadow, including this write, is copied to tuple_addr/tuple_way.
  - tuple_valid=1 on the next cycle -> HOLD.
  - Latency: last write to valid is 1 cycle.
- COLLECT, indicator: ignored, no restart.
- COLLECT, abort=1:
  - -> IDLE, fill_count=0, tuple outputs unchanged, no valid.
  - abort has priority over write_en in the same cycle.
- COLLECT, timeout (TIMEOUT>0):
  - The counter increments on each COLLECT cycle without write_en.
  - When it reaches TIMEOUT -> IDLE, timeout_err=1 for exactly one cycle, fill_count=0, outputs unchanged.
  - abort takes priority over timeout.
  - A write on the cycle the counter would expire wins: the entry is captured and the counter clears.
- HOLD:
  - tuple_valid, tuple_addr and tuple_way are held stable until tuple_valid && out_ready.
  - write_en and abort are ignored.
  - indicator (or indicator on the handshake cycle) sets the pending flag, depth 1; extra indicators are dropped.
- HOLD, handshake:
  - tuple_valid=0 next cycle.
  - If pending=1 -> COLLECT with fill_count=0 and pending cleared; else -> IDLE.
  - The next tuple's first write may arrive in the cycle after the handshake.
- fill_count reads 0 in IDLE and HOLD.
- Arithmetic: counters saturate-free; only legal values are reachable. No width truncation of addr/way.

Decomposition:
- Shared package plc_pkg:
  - State encoding constants PLC_IDLE=2'b00, PLC_COLLECT=2'b01, PLC_HOLD=2'b10.
  - Localparam helpers for slice offsets (slot i MS index = (TUPLE_LEN-i)*W-1).
- One natural sub-module: plc_tuple_shadow, a parametrised slot-indexed register file holding the TUPLE_LEN (addr, way) entries with write-by-index and clear.
- FSM, counters and handshake live in the top.

Test Plan:
- TUPLE_LEN=3, out_ready=1: indicator, then writes (0x11,1),(0x22,2),(0x33,3) on consecutive cycles -> tuple_valid=1 one cycle after the third write; tuple_addr=0x112233, tuple_way=0x123; valid drops the next cycle.
- Same tuple, out_ready=0 for 5 cycles: valid and data stable for 5 cycles; extra write_en (0x44,4) ignored; raising out_ready -> IDLE, valid=0.
- TIMEOUT=4: indicator, one write (0xAA,5), then 4 idle cycles -> timeout_err pulses exactly 1 cycle; state IDLE; prior tuple outputs unchanged; no valid.
- indicator, write (0x01,1), then abort and write_en in the same cycle -> IDLE, fill_count=0, write discarded, no valid.
- In HOLD, pulse indicator twice, then handshake -> goes straight to COLLECT (single pending); writes (0x55,1),(0x66,2),(0x77,3) -> second tuple 0x556677 / 0x123.
- rst_n=0 asserted mid-COLLECT after 2 writes -> next edge: all outputs 0, IDLE; later writes without indicator are not captured.
